// File: rtl/chunked_negator.sv
// chunked_negator: multi-cycle pass / invert / negate / abs unit.
// The operand is processed CHUNK bits per cycle, least significant chunk first,
// with the negate carry held in a register between chunks. This keeps the carry
// chain only CHUNK bits long. valid/ready handshakes are used on input and output.
module chunked_negator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {OP_PASS, OP_INV, OP_NEG} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    op_t              eff_op;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK:0]   neg_sum;
    logic [CHUNK-1:0] res_chunk;
    logic [WIDTH-1:0] shifted;

    // The operand register shifts right one chunk per BUSY cycle while result
    // chunks enter at the top, so after NCHUNK cycles it holds the full result
    // and the current chunk is always the low CHUNK bits.
    assign x_chunk = data_q[CHUNK-1:0];
    assign neg_sum = {1'b0, ~x_chunk} + {{CHUNK{1'b0}}, carry_q};

    // Per-chunk transform selected by the captured effective operation.
    always_comb begin
        case (op_q)
            OP_INV:  res_chunk = ~x_chunk;
            OP_NEG:  res_chunk = neg_sum[CHUNK-1:0];
            default: res_chunk = x_chunk;
        endcase
    end

    generate
        if (NCHUNK > 1) begin : g_multi
            assign shifted = {res_chunk, data_q[WIDTH-1:CHUNK]};
        end else begin : g_single
            assign shifted = res_chunk;
        end
    endgenerate

    // Abs collapses to negate or pass at accept time, so BUSY sees only three ops.
    always_comb begin
        case (in_mode)
            2'b00:   eff_op = OP_PASS;
            2'b01:   eff_op = OP_INV;
            2'b10:   eff_op = OP_NEG;
            default: eff_op = in_data[WIDTH-1] ? OP_NEG : OP_PASS;
        endcase
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;

    // Next-state and datapath control for IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        data_d     = data_q;
        ovf_pend_d = ovf_pend_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    op_d       = eff_op;
                    carry_d    = (eff_op == OP_NEG);
                    idx_d      = '0;
                    ovf_pend_d = (eff_op == OP_NEG) && (in_data == MOST_NEG);
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                data_d = shifted;
                idx_d  = idx_q + IDX_W'(1);
                if (op_q == OP_NEG) begin
                    carry_d = neg_sum[CHUNK];
                end
                if (idx_q == LAST_IDX) begin
                    out_data_d = shifted;
                    out_ovf_d  = ovf_pend_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and visible outputs, with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    // Operand working register and captured op; loaded on every accept.
    always_ff @(posedge clock) begin
        // NOTE: these are deliberately not reset; they are always written on
        // accept before being read, so a reset would only add routing.
        data_q     <= data_d;
        op_q       <= op_d;
        ovf_pend_q <= ovf_pend_d;
    end

endmodule
